if_id_stage: RTL and testbench

Pipeline boundary between the fetch stage and the decode stage of the RV32I core. Registers each fetched instruction with its PC and a valid flag. Holds those outputs while the data-memory stall is active, and catches an in-flight beat in a one-entry skid buffer. On a control-flow redirect it kills the wrong-path instruction and inserts bubbles, so the decode stage sees either a valid instruction or a canonical NOP.

---
 rtl/if_id_stage.sv | 137 +++++++++++++
 tb/tb_if_id_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer and flush/drop handling.
// Latency: one cycle from an accepted fetch beat to the decode outputs.
// Backpressure: stall holds the output register, and fetch_ready falls once the skid buffer is occupied.
module if_id_stage #(
  parameter int ADDRESS     = 32,
  parameter int INSTRUCTION = 32,
  parameter int FLUSH_DROP  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [INSTRUCTION-1:0] instruction_in,
  input  logic [ADDRESS-1:0]     pc_in,
  output logic                   fetch_ready,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic                   valid_out,
  output logic [INSTRUCTION-1:0] instruction_out,
  output logic [ADDRESS-1:0]     pc_out,
  output logic [ADDRESS-1:0]     pc_plus4_out
);

  localparam logic [INSTRUCTION-1:0] NOP      = INSTRUCTION'(32'h0000_0013);
  localparam logic [2:0]             DROP_CNT = 3'(FLUSH_DROP);

  typedef enum logic [1:0] {RUN, STALL, DROP} state_t;

  state_t                 state, state_n;
  logic [2:0]             cnt, cnt_n;
  logic                   or_valid, or_valid_n;
  logic [INSTRUCTION-1:0] or_instr, or_instr_n;
  logic [ADDRESS-1:0]     or_pc, or_pc_n;
  logic [ADDRESS-1:0]     or_pc4, or_pc4_n;
  logic                   sb_valid, sb_valid_n;
  logic [INSTRUCTION-1:0] sb_instr, sb_instr_n;
  logic [ADDRESS-1:0]     sb_pc, sb_pc_n;
  logic                   ready_n;
  logic                   accept;

  assign accept = fetch_valid && fetch_ready;

  // Next-state and next-contents for the output register, skid buffer and drop counter.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    or_valid_n = or_valid;
    or_instr_n = or_instr;
    or_pc_n    = or_pc;
    sb_valid_n = sb_valid;
    sb_instr_n = sb_instr;
    sb_pc_n    = sb_pc;

    if (flush_in) begin
      // Redirect beats everything: kill both entries and start discarding wrong-path beats.
      or_valid_n = 1'b0;
      sb_valid_n = 1'b0;
      if (DROP_CNT == 3'd0) begin
        state_n = stall_in ? STALL : RUN;
      end else begin
        state_n = DROP;
        cnt_n   = DROP_CNT;
      end
    end else begin
      case (state)
        DROP: begin
          // Accepted beats are thrown away; counter runs regardless of stall.
          or_valid_n = 1'b0;
          cnt_n      = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
          if (cnt <= 3'd1) state_n = stall_in ? STALL : RUN;
        end
        default: begin
          if (stall_in) begin
            // Output register holds; an in-flight beat is caught by the skid buffer.
            state_n = STALL;
            if (accept) begin
              sb_valid_n = 1'b1;
              sb_instr_n = instruction_in;
              sb_pc_n    = pc_in;
            end
          end else begin
            state_n = RUN;
            if (sb_valid) begin
              or_valid_n = 1'b1;
              or_instr_n = sb_instr;
              or_pc_n    = sb_pc;
              sb_valid_n = 1'b0;
            end else if (accept) begin
              or_valid_n = 1'b1;
              or_instr_n = instruction_in;
              or_pc_n    = pc_in;
            end else begin
              or_valid_n = 1'b0;
            end
          end
        end
      endcase
    end

    // pc_plus4 always tracks pc; when pc holds this reproduces the stored value.
    or_pc4_n = or_pc_n + ADDRESS'(4);
    // The skid buffer is the only thing that can refuse a beat.
    ready_n  = !sb_valid_n;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 3'd0;
      or_valid    <= 1'b0;
      or_instr    <= NOP;
      or_pc       <= '0;
      or_pc4      <= ADDRESS'(4);
      sb_valid    <= 1'b0;
      sb_instr    <= NOP;
      sb_pc       <= '0;
      fetch_ready <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      or_valid    <= or_valid_n;
      or_instr    <= or_instr_n;
      or_pc       <= or_pc_n;
      or_pc4      <= or_pc4_n;
      sb_valid    <= sb_valid_n;
      sb_instr    <= sb_instr_n;
      sb_pc       <= sb_pc_n;
      fetch_ready <= ready_n;
    end
  end

  assign valid_out       = or_valid;
  assign instruction_out = or_valid ? or_instr : NOP;
  assign pc_out          = or_pc;
  assign pc_plus4_out    = or_pc4;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a queue-based reference model.
// Compare process checks every output one time unit after each rising edge.
// Literal expectations at key points pin the model to hand-computed values.
module tb_if_id_stage;

  localparam int FD = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic        fetch_ready;
  logic        stall_in;
  logic        flush_in;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;

  int errors = 0;
  int checks = 0;

  if_id_stage #(.ADDRESS(32), .INSTRUCTION(32), .FLUSH_DROP(FD)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .instruction_in(instruction_in), .pc_in(pc_in),
    .fetch_ready(fetch_ready), .stall_in(stall_in), .flush_in(flush_in),
    .valid_out(valid_out), .instruction_out(instruction_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
  );

  always #5 clk = ~clk;

  // Reference model: beats waiting behind a stall, the visible decode slot, and drop budget.
  logic [31:0] q[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_ready;
  int          m_drop;
  logic        check_en = 1'b0;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[19:0], 12'h093};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_ready = 1'b1;
    m_drop  = 0;
  endtask

  task automatic model_show(input logic [31:0] pc);
    m_valid = 1'b1;
    m_pc    = pc;
  endtask

  // Drive one cycle of inputs, advance the model, then let the edge happen.
  task automatic step(input logic fv, input logic [31:0] pc, input logic st, input logic fl);
    logic acc;
    fetch_valid    = fv;
    pc_in          = pc;
    instruction_in = ins(pc);
    stall_in       = st;
    flush_in       = fl;
    acc = fv && m_ready;
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
      m_drop  = FD;
    end else if (m_drop > 0) begin
      m_drop--;
      m_valid = 1'b0;
    end else if (st) begin
      if (acc) q.push_back(pc);
    end else if (q.size() > 0) begin
      model_show(q.pop_front());
    end else if (acc) begin
      model_show(pc);
    end else begin
      m_valid = 1'b0;
    end
    m_ready = (q.size() == 0);
    @(posedge clk);
    #2;
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
      chk("instruction_out", instruction_out, m_valid ? ins(m_pc) : NOP);
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4_out", pc_plus4_out, m_pc + 32'd4);
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_ready});
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, " valid"}, {31'b0, valid_out}, 32'd0);
    chk({tag, " instr"}, instruction_out, NOP);
    chk({tag, " pc"}, pc_out, 32'h0);
    chk({tag, " pc4"}, pc_plus4_out, 32'h4);
    chk({tag, " ready"}, {31'b0, fetch_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0; instruction_in = '0; pc_in = '0;
    stall_in = 1'b0; flush_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    // 1. Streaming
    step(1, 32'h0, 0, 0);  chk("s1 pc4 0", pc_plus4_out, 32'h4);
    step(1, 32'h4, 0, 0);  chk("s1 pc4 4", pc_plus4_out, 32'h8);
    step(1, 32'h8, 0, 0);  chk("s1 pc4 8", pc_plus4_out, 32'hC);
    chk("s1 valid", {31'b0, valid_out}, 32'd1);
    step(1, 32'hC, 0, 0);
    step(1, 32'h10, 0, 0);

    // 2. Stall with skid: 0x14 caught in SB, then 0x18 re-presented until taken
    step(1, 32'h14, 1, 0); chk("s2 hold pc", pc_out, 32'h10); chk("s2 ready low", {31'b0, fetch_ready}, 32'd0);
    step(1, 32'h18, 1, 0); chk("s2 hold pc b", pc_out, 32'h10);
    step(1, 32'h18, 1, 0); chk("s2 ready still low", {31'b0, fetch_ready}, 32'd0);
    step(1, 32'h18, 0, 0); chk("s2 drain pc", pc_out, 32'h14); chk("s2 ready up", {31'b0, fetch_ready}, 32'd1);
    step(1, 32'h18, 0, 0); chk("s2 next pc", pc_out, 32'h18);
    step(1, 32'h1C, 0, 0);
    step(1, 32'h20, 0, 0);

    // 3. Flush while 0x20 is in OR
    step(1, 32'h24, 0, 1); chk("s3 bubble valid", {31'b0, valid_out}, 32'd0); chk("s3 nop", instruction_out, NOP);
    step(1, 32'h24, 0, 0); chk("s3 dropped", {31'b0, valid_out}, 32'd0);
    step(1, 32'h100, 0, 0); chk("s3 target", pc_out, 32'h100); chk("s3 target instr", instruction_out, 32'h00100093);

    // 4. Flush and stall together with SB occupied
    step(1, 32'h104, 0, 0);
    step(1, 32'h108, 1, 0);
    step(1, 32'h10C, 1, 1); chk("s4 flush wins", {31'b0, valid_out}, 32'd0); chk("s4 sb cleared", {31'b0, fetch_ready}, 32'd1);
    step(0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 0);   chk("s4 no stale", {31'b0, valid_out}, 32'd0);
    step(1, 32'h200, 0, 0); chk("s4 target", pc_out, 32'h200);

    // 5. PC wrap
    step(1, 32'hFFFF_FFFC, 0, 0); chk("s5 wrap", pc_plus4_out, 32'h0);
    step(1, 32'h0, 0, 0);

    // 6a. Asynchronous reset with SB full
    step(1, 32'h4, 0, 0);
    step(1, 32'h8, 1, 0);
    check_en = 1'b0;
    fetch_valid = 1'b0; stall_in = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("arst sb");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    step(1, 32'h40, 0, 0);

    // 6b. Asynchronous reset mid-DROP
    step(1, 32'h44, 0, 1);
    check_en = 1'b0;
    fetch_valid = 1'b0; flush_in = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("arst drop");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    step(1, 32'h80, 0, 0); chk("post reset beat", pc_out, 32'h80);
    step(0, 32'h0, 0, 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
